// File: rtl/ballot_sender.sv
// rtl/ballot_sender.sv - ballot transmitter: Finish pulse, then four held digits separated by gaps
module ballot_sender #(
    parameter int HOLD_CYCLES = 1,
    parameter int GAP_CYCLES  = 1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic        cancel_i,
    input  logic [15:0] code_i,
    output logic [3:0]  digit_o,
    output logic        valid_o,
    output logic        finish_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [7:0]  sent_o
);
    typedef enum logic [2:0] {IDLE, FIN, FGAP, HOLD, DGAP, DONE} state_t;

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);
    localparam logic [3:0] GAP_LAST  = 4'(GAP_CYCLES - 1);

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] code_q, code_d;
    logic [3:0]  digit_q, digit_d;
    logic        valid_q, valid_d;
    logic        finish_q, finish_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [7:0]  sent_q, sent_d;
    logic [3:0]  nib;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start_i && !cancel_i) begin
                    code_d  = code_i;
                    idx_d   = 2'd0;
                    cnt_d   = 4'd0;
                    state_d = FIN;
                end
            end
            FIN: begin
                cnt_d   = 4'd0;
                state_d = FGAP;
            end
            FGAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = 4'd0;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = 4'd0;
                    state_d = DGAP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DGAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = 4'd0;
                    if (idx_q == 2'd3) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = HOLD;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Cancel only matters mid-ballot; in IDLE/DONE it merely blocks acceptance above.
        if (cancel_i && busy_q) begin
            state_d = IDLE;
            idx_d   = 2'd0;
            cnt_d   = 4'd0;
        end
    end

    always_comb begin
        case (idx_d)
            2'd0:    nib = code_d[15:12];
            2'd1:    nib = code_d[11:8];
            2'd2:    nib = code_d[7:4];
            default: nib = code_d[3:0];
        endcase
    end

    // Outputs are decoded from the next state so they appear registered in the same cycle as the state.
    always_comb begin
        finish_d = (state_d == FIN);
        valid_d  = (state_d == HOLD);
        digit_d  = valid_d ? nib : 4'd0;
        busy_d   = (state_d == FIN) || (state_d == FGAP) || (state_d == HOLD) || (state_d == DGAP);
        done_d   = (state_d == DONE);
        sent_d   = sent_q;
        if (done_d && sent_q != 8'hFF) begin
            sent_d = sent_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            idx_q    <= 2'd0;
            cnt_q    <= 4'd0;
            code_q   <= 16'd0;
            digit_q  <= 4'd0;
            valid_q  <= 1'b0;
            finish_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sent_q   <= 8'd0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            code_q   <= code_d;
            digit_q  <= digit_d;
            valid_q  <= valid_d;
            finish_q <= finish_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            sent_q   <= sent_d;
        end
    end

    assign digit_o  = digit_q;
    assign valid_o  = valid_q;
    assign finish_o = finish_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign sent_o   = sent_q;
endmodule

// File: tb/tb_ballot_sender.sv
// tb/tb_ballot_sender.sv - directed table and sequence checks for ballot_sender
module tb_ballot_sender;
    logic        clk = 1'b0;
    logic        reset, start, cancel;
    logic [15:0] code;
    logic [3:0]  digit, digit2;
    logic        valid, finish, busy, done, valid2, finish2, busy2, done2;
    logic [7:0]  sent, sent2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ballot_sender dut (
        .clk_i(clk), .reset_i(reset), .start_i(start), .cancel_i(cancel), .code_i(code),
        .digit_o(digit), .valid_o(valid), .finish_o(finish), .busy_o(busy),
        .done_o(done), .sent_o(sent)
    );

    ballot_sender #(.HOLD_CYCLES(3), .GAP_CYCLES(2)) dut2 (
        .clk_i(clk), .reset_i(reset), .start_i(start), .cancel_i(cancel), .code_i(code),
        .digit_o(digit2), .valid_o(valid2), .finish_o(finish2), .busy_o(busy2),
        .done_o(done2), .sent_o(sent2)
    );

    typedef struct {
        logic        st;
        logic        cn;
        logic [15:0] code;
        logic [3:0]  dg;
        logic        vl;
        logic        fn;
        logic        bs;
        logic        dn;
        logic [7:0]  sent;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [16:0] pack(logic [3:0] d, logic v, logic f, logic b, logic n, logic [7:0] s);
        return {d, v, f, b, n, s};
    endfunction

    task automatic check(string name, int idx, logic [16:0] got, logic [16:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s #%0d: got dig/v/f/b/d/sent=%h want %h", name, idx, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(logic st, logic cn, logic [15:0] c, logic [3:0] d, logic v, logic f,
                       logic b, logic n, logic [7:0] s);
        vec_t e;
        e.st = st; e.cn = cn; e.code = c; e.dg = d; e.vl = v; e.fn = f; e.bs = b; e.dn = n; e.sent = s;
        tbl.push_back(e);
    endtask

    // Full default-timing ballot: accept, FIN, FGAP, 4x(HOLD,DGAP), DONE.
    task automatic add_ballot(logic [15:0] c, logic [7:0] s0, logic st_rest, logic [15:0] c_rest);
        logic [15:0] cc;
        cc = c;
        add(1, 0, c, 0, 0, 1, 1, 0, s0);
        add(st_rest, 0, c_rest, 0, 0, 0, 1, 0, s0);
        for (int k = 0; k < 4; k++) begin
            add(st_rest, 0, c_rest, cc[15-4*k -: 4], 1, 0, 1, 0, s0);
            add(st_rest, 0, c_rest, 0, 0, 0, 1, 0, s0);
        end
        add(st_rest, 0, c_rest, 0, 0, 0, 0, 1, s0 + 8'd1);
    endtask

    task automatic run_ballot(logic [15:0] c);
        start = 1; code = c;
        step();
        start = 0;
        repeat (10) step();
    endtask

    initial begin
        logic [16:0] got;
        logic        ev;
        logic [3:0]  ed;
        logic [15:0] c2;
        reset = 1; start = 1; cancel = 1; code = 16'hFFFF;
        step();
        step();
        check("reset", 0, pack(digit, valid, finish, busy, done, sent), 17'd0);
        reset = 0; start = 0; cancel = 0; code = 16'h0;

        add_ballot(16'h3494, 8'd0, 1'b0, 16'h0000);
        add(0, 0, 0, 0, 0, 0, 0, 0, 1);
        add_ballot(16'h3485, 8'd1, 1'b1, 16'h3504);
        add_ballot(16'h3504, 8'd2, 1'b0, 16'h0000);
        add(0, 0, 0, 0, 0, 0, 0, 0, 3);
        add_ballot(16'h30F4, 8'd3, 1'b0, 16'h0000);
        add(0, 0, 0, 0, 0, 0, 0, 0, 4);
        add(1, 0, 16'h3494, 0, 0, 1, 1, 0, 4);
        add(0, 0, 0, 0, 0, 0, 1, 0, 4);
        add(0, 0, 0, 3, 1, 0, 1, 0, 4);
        add(0, 0, 0, 0, 0, 0, 1, 0, 4);
        add(0, 0, 0, 4, 1, 0, 1, 0, 4);
        add(0, 1, 0, 0, 0, 0, 0, 0, 4);
        add(0, 0, 0, 0, 0, 0, 0, 0, 4);
        add(1, 1, 16'h1234, 0, 0, 0, 0, 0, 4);
        add(0, 0, 0, 0, 0, 0, 0, 0, 4);
        add_ballot(16'h1234, 8'd4, 1'b0, 16'h0000);
        add(0, 0, 0, 0, 0, 0, 0, 0, 5);

        for (int i = 0; i < tbl.size(); i++) begin
            start = tbl[i].st; cancel = tbl[i].cn; code = tbl[i].code;
            step();
            check("table", i, pack(digit, valid, finish, busy, done, sent),
                  pack(tbl[i].dg, tbl[i].vl, tbl[i].fn, tbl[i].bs, tbl[i].dn, tbl[i].sent));
            if (valid && finish) check("overlap", i, 17'd1, 17'd0);
        end
        start = 0; cancel = 0;

        // HOLD=3, GAP=2: FIN at 1, holds at 4+5k for 3 cycles, Done at 2+G+4(H+G)=24.
        reset = 1;
        step();
        reset = 0;
        c2 = 16'h3472;
        start = 1; code = c2;
        step();
        start = 0; code = 16'h0;
        for (int c = 1; c <= 27; c++) begin
            ev = 0; ed = 0;
            for (int k = 0; k < 4; k++) begin
                if (c >= 4 + 5*k && c <= 6 + 5*k) begin
                    ev = 1;
                    ed = c2[15-4*k -: 4];
                end
            end
            check("hold3gap2", c, pack(digit2, valid2, finish2, busy2, done2, sent2),
                  pack(ed, ev, c == 1, c <= 23, c == 24, (c >= 24) ? 8'd1 : 8'd0));
            if (c < 27) step();
        end

        // Reset mid-ballot after three completed ballots.
        reset = 1;
        step();
        reset = 0;
        run_ballot(16'h1111);
        run_ballot(16'h2222);
        run_ballot(16'h3333);
        start = 1; code = 16'h3494;
        step();
        start = 0;
        repeat (5) step();
        check("pre_reset", 0, pack(digit, valid, finish, busy, done, sent),
              pack(4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd3));
        reset = 1;
        step();
        reset = 0;
        check("mid_reset", 0, pack(digit, valid, finish, busy, done, sent), 17'd0);
        for (int i = 1; i <= 4; i++) begin
            step();
            check("post_reset", i, pack(digit, valid, finish, busy, done, sent), 17'd0);
        end
        start = 1; cancel = 1; code = 16'h9999;
        step();
        check("start_cancel", 0, pack(digit, valid, finish, busy, done, sent), 17'd0);
        start = 0; cancel = 0;

        // Saturation.
        reset = 1;
        step();
        reset = 0;
        for (int b = 1; b <= 256; b++) begin
            run_ballot(16'h3494);
            if (b == 254 || b == 255 || b == 256) begin
                got = pack(digit, valid, finish, busy, done, sent);
                check("saturate", b, got, pack(4'd0, 1'b0, 1'b0, 1'b0, 1'b1, (b == 254) ? 8'd254 : 8'd255));
            end
        end
        step();
        check("sat_idle", 0, pack(digit, valid, finish, busy, done, sent), pack(0, 0, 0, 0, 0, 8'd255));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
